// File: rtl/wr_link_emu_pkg.sv
// rtl/wr_link_emu_pkg.sv - shared types, widths and channel numbering for the link emulator
package wr_link_emu_pkg;

    localparam int c_link_emu_err_cnt_width  = 32;
    localparam int c_link_emu_max_delay_bits = 16;
    localparam int c_link_emu_max_data_width = 32;
    localparam int c_link_emu_period_width   = 16;

    // Fields sized for the widest supported build; channels narrow them on use.
    typedef struct packed {
        logic [c_link_emu_max_delay_bits-1:0] delay;
        logic                                 up;
        logic [c_link_emu_period_width-1:0]   err_period;
        logic [c_link_emu_max_data_width-1:0] err_mask;
    } t_link_emu_cfg;

    // dir 0 is A->B, dir 1 is B->A
    function automatic int f_chan_index(input int link, input int dir);
        return 2 * link + dir;
    endfunction

endpackage

// File: rtl/wr_link_emu_channel.sv
// rtl/wr_link_emu_channel.sv - one emulated fibre direction: delay ring, refill FSM, error injector
module wr_link_emu_channel
    import wr_link_emu_pkg::*;
#(
    parameter int                     g_data_width = 20,
    parameter int                     g_delay_bits = 8,
    parameter logic [g_data_width-1:0] g_fill_word  = 20'h0F83E
) (
    input  logic                                clk_sys_i,
    input  logic                                rst_i,
    input  logic [g_data_width-1:0]             tx_i,
    output logic [g_data_width-1:0]             rx_o,
    input  logic                                cfg_we_i,
    input  logic [g_delay_bits-1:0]             cfg_delay_i,
    input  logic                                cfg_up_i,
    input  logic [c_link_emu_period_width-1:0]  cfg_err_period_i,
    input  logic [g_data_width-1:0]             cfg_err_mask_i,
    output logic [c_link_emu_err_cnt_width-1:0] err_total_o
);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [g_data_width-1:0] ring_q [2**g_delay_bits];

    logic [g_delay_bits-1:0]             wr_ptr_q, wr_ptr_d;
    logic [g_delay_bits-1:0]             fill_cnt_q, fill_cnt_d;
    logic [0:0]                          state_q, state_d;
    logic [c_link_emu_period_width-1:0]  err_cnt_q, err_cnt_d;
    logic [c_link_emu_err_cnt_width-1:0] err_total_q, err_total_d;
    logic [g_data_width-1:0]             rx_q, rx_d;
    t_link_emu_cfg                       cfg_q, cfg_d;

    logic [g_delay_bits-1:0] delay;
    logic [g_delay_bits-1:0] rd_ptr;
    logic [g_data_width-1:0] mask;
    logic [g_data_width-1:0] rd_word;
    logic                    inject;

    always_comb begin
        delay    = g_delay_bits'(cfg_q.delay);
        mask     = g_data_width'(cfg_q.err_mask);
        rd_ptr   = wr_ptr_q - delay;
        // Zero delay bypasses the ring so latency stays at the single output register.
        rd_word  = (delay == '0) ? tx_i : ring_q[rd_ptr];
        inject   = 1'b0;

        wr_ptr_d    = wr_ptr_q + g_delay_bits'(1);
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_total_d = err_total_q;
        cfg_d       = cfg_q;

        if (state_q == ST_RUN && cfg_q.up && cfg_q.err_period != '0) begin
            if (err_cnt_q == cfg_q.err_period - c_link_emu_period_width'(1)) begin
                inject    = 1'b1;
                err_cnt_d = '0;
                if (err_total_q != '1) begin
                    err_total_d = err_total_q + c_link_emu_err_cnt_width'(1);
                end
            end else begin
                err_cnt_d = err_cnt_q + c_link_emu_period_width'(1);
            end
        end

        if (state_q == ST_FILL) begin
            fill_cnt_d = fill_cnt_q + g_delay_bits'(1);
            if (fill_cnt_q == delay) begin
                state_d = ST_RUN;
            end
        end

        if (!cfg_q.up) begin
            rx_d = '0;
        end else if (state_q == ST_FILL) begin
            rx_d = g_fill_word;
        end else if (inject) begin
            rx_d = rd_word ^ mask;
        end else begin
            rx_d = rd_word;
        end

        // A write restarts the refill and overrides any FILL->RUN step this cycle.
        if (cfg_we_i) begin
            cfg_d.delay      = c_link_emu_max_delay_bits'(cfg_delay_i);
            cfg_d.up         = cfg_up_i;
            cfg_d.err_period = cfg_err_period_i;
            cfg_d.err_mask   = c_link_emu_max_data_width'(cfg_err_mask_i);
            state_d          = ST_FILL;
            fill_cnt_d       = '0;
            err_cnt_d        = '0;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        ring_q[wr_ptr_q] <= tx_i;
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            state_q     <= ST_FILL;
            err_cnt_q   <= '0;
            err_total_q <= '0;
            rx_q        <= '0;
            cfg_q       <= '{delay: '0, up: 1'b1, err_period: '0, err_mask: '0};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            state_q     <= state_d;
            err_cnt_q   <= err_cnt_d;
            err_total_q <= err_total_d;
            rx_q        <= rx_d;
            cfg_q       <= cfg_d;
        end
    end

    assign rx_o        = rx_q;
    assign err_total_o = err_total_q;

endmodule

// File: rtl/wr_link_emulator.sv
// rtl/wr_link_emulator.sv - multi-link fibre emulator: per-direction channels, cfg decode, status mux
module wr_link_emulator
    import wr_link_emu_pkg::*;
#(
    parameter int                     g_num_links  = 2,
    parameter int                     g_data_width = 20,
    parameter int                     g_delay_bits = 8,
    parameter logic [g_data_width-1:0] g_fill_word  = 20'h0F83E
) (
    input  logic                                  clk_sys_i,
    input  logic                                  rst_i,
    input  logic [g_num_links*g_data_width-1:0]   a_tx_i,
    output logic [g_num_links*g_data_width-1:0]   a_rx_o,
    input  logic [g_num_links*g_data_width-1:0]   b_tx_i,
    output logic [g_num_links*g_data_width-1:0]   b_rx_o,
    input  logic                                  cfg_we_i,
    input  logic [$clog2(2*g_num_links)-1:0]      cfg_chan_i,
    input  logic [g_delay_bits-1:0]               cfg_delay_i,
    input  logic                                  cfg_up_i,
    input  logic [15:0]                           cfg_err_period_i,
    input  logic [g_data_width-1:0]               cfg_err_mask_i,
    input  logic [$clog2(2*g_num_links)-1:0]      stat_chan_i,
    output logic [31:0]                           stat_err_cnt_o
);

    localparam int c_num_chan  = 2 * g_num_links;
    localparam int c_chan_bits = $clog2(c_num_chan);

    logic [c_link_emu_err_cnt_width-1:0] err_total [c_num_chan];
    logic [c_link_emu_err_cnt_width-1:0] stat_q, stat_d;

    for (genvar k = 0; k < g_num_links; k++) begin : g_link
        localparam int c_ab = f_chan_index(k, 0);
        localparam int c_ba = f_chan_index(k, 1);

        wr_link_emu_channel #(
            .g_data_width (g_data_width),
            .g_delay_bits (g_delay_bits),
            .g_fill_word  (g_fill_word)
        ) u_a_to_b (
            .clk_sys_i        (clk_sys_i),
            .rst_i            (rst_i),
            .tx_i             (a_tx_i[k*g_data_width +: g_data_width]),
            .rx_o             (b_rx_o[k*g_data_width +: g_data_width]),
            .cfg_we_i         (cfg_we_i && (cfg_chan_i == c_chan_bits'(c_ab))),
            .cfg_delay_i      (cfg_delay_i),
            .cfg_up_i         (cfg_up_i),
            .cfg_err_period_i (cfg_err_period_i),
            .cfg_err_mask_i   (cfg_err_mask_i),
            .err_total_o      (err_total[c_ab])
        );

        wr_link_emu_channel #(
            .g_data_width (g_data_width),
            .g_delay_bits (g_delay_bits),
            .g_fill_word  (g_fill_word)
        ) u_b_to_a (
            .clk_sys_i        (clk_sys_i),
            .rst_i            (rst_i),
            .tx_i             (b_tx_i[k*g_data_width +: g_data_width]),
            .rx_o             (a_rx_o[k*g_data_width +: g_data_width]),
            .cfg_we_i         (cfg_we_i && (cfg_chan_i == c_chan_bits'(c_ba))),
            .cfg_delay_i      (cfg_delay_i),
            .cfg_up_i         (cfg_up_i),
            .cfg_err_period_i (cfg_err_period_i),
            .cfg_err_mask_i   (cfg_err_mask_i),
            .err_total_o      (err_total[c_ba])
        );
    end

    always_comb begin
        stat_d = '0;
        for (int i = 0; i < c_num_chan; i++) begin
            if (stat_chan_i == c_chan_bits'(i)) begin
                stat_d = err_total[i];
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_err_cnt_o = stat_q;

endmodule

// File: tb/tb_wr_link_emulator.sv
// tb/tb_wr_link_emulator.sv - scoreboard bench for the link emulator
module tb_wr_link_emulator;

    localparam int            W    = 20;
    localparam logic [19:0]   FILL = 20'h0F83E;
    localparam int            SIG_STAT = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [39:0] a_tx_i, b_tx_i, a_rx_o, b_rx_o;
    logic        cfg_we_i;
    logic [1:0]  cfg_chan_i;
    logic [7:0]  cfg_delay_i;
    logic        cfg_up_i;
    logic [15:0] cfg_err_period_i;
    logic [19:0] cfg_err_mask_i;
    logic [1:0]  stat_chan_i;
    logic [31:0] stat_err_cnt_o;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        int          c;
        int          sig;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    wr_link_emulator #(
        .g_num_links  (2),
        .g_data_width (W),
        .g_delay_bits (8),
        .g_fill_word  (FILL)
    ) dut (
        .clk_sys_i        (clk),
        .rst_i            (rst_i),
        .a_tx_i           (a_tx_i),
        .a_rx_o           (a_rx_o),
        .b_tx_i           (b_tx_i),
        .b_rx_o           (b_rx_o),
        .cfg_we_i         (cfg_we_i),
        .cfg_chan_i       (cfg_chan_i),
        .cfg_delay_i      (cfg_delay_i),
        .cfg_up_i         (cfg_up_i),
        .cfg_err_period_i (cfg_err_period_i),
        .cfg_err_mask_i   (cfg_err_mask_i),
        .stat_chan_i      (stat_chan_i),
        .stat_err_cnt_o   (stat_err_cnt_o)
    );

    always #5 clk = ~clk;

    // Word transmitted on channel ch's input during cycle n; never equals FILL.
    function automatic logic [19:0] word(int ch, int n);
        int t;
        t = (n << 3) | ((ch / 2) << 1) | (ch % 2);
        return t[19:0];
    endfunction

    function automatic logic [31:0] sample(int sig);
        int link;
        link = sig / 2;
        if (sig == SIG_STAT) return stat_err_cnt_o;
        if (sig % 2 == 0)    return {12'h0, b_rx_o[link*W +: W]};
        return {12'h0, a_rx_o[link*W +: W]};
    endfunction

    function automatic string sig_name(int sig);
        case (sig)
            0:       return "b_rx_link0";
            1:       return "a_rx_link0";
            2:       return "b_rx_link1";
            3:       return "a_rx_link1";
            default: return "stat_err_cnt";
        endcase
    endfunction

    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].c == cyc) begin
                act = sample(sb[i].sig);
                n_total++;
                if (act !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sig_name(sb[i].sig), cyc, act, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].c < cyc) begin
                n_total++;
                n_bad++;
                $display("FAIL %s cyc=%0d never sampled want=%h", sig_name(sb[i].sig), sb[i].c, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic exp1(int c, int sig, logic [31:0] v);
        exp_t e;
        e.c = c; e.sig = sig; e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_const(int sig, int c0, int c1, logic [31:0] v);
        for (int c = c0; c <= c1; c++) exp1(c, sig, v);
    endtask

    // Data at cycle c is the word sent lat cycles earlier; RUN word k = c-base is errored when k%p==0.
    task automatic exp_data(int sig, int c0, int c1, int lat, int base, int p, logic [19:0] msk);
        logic [19:0] v;
        for (int c = c0; c <= c1; c++) begin
            v = word(sig, c - lat);
            if (p != 0 && ((c - base) % p) == 0) v = v ^ msk;
            exp1(c, sig, {12'h0, v});
        end
    endtask

    task automatic drive_tx();
        for (int k = 0; k < 2; k++) begin
            a_tx_i[k*W +: W] = word(2*k, cyc);
            b_tx_i[k*W +: W] = word(2*k + 1, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cfg_we_i = 1'b0;
        drive_tx();
    endtask

    task automatic tick_to(int n);
        while (cyc < n) tick();
    endtask

    task automatic cfg_write(int ch, int dly, logic up, int p, logic [19:0] msk);
        cfg_we_i         = 1'b1;
        cfg_chan_i       = ch[1:0];
        cfg_delay_i      = dly[7:0];
        cfg_up_i         = up;
        cfg_err_period_i = p[15:0];
        cfg_err_mask_i   = msk;
    endtask

    initial begin
        rst_i            = 1'b1;
        cfg_we_i         = 1'b0;
        cfg_chan_i       = 2'd0;
        cfg_delay_i      = 8'd0;
        cfg_up_i         = 1'b0;
        cfg_err_period_i = 16'd0;
        cfg_err_mask_i   = 20'd0;
        stat_chan_i      = 2'd2;
        drive_tx();

        for (int ch = 0; ch < 4; ch++) exp1(2, ch, 32'h0);
        exp1(2, SIG_STAT, 32'd0);

        tick_to(3);
        rst_i = 1'b0;
        for (int ch = 0; ch < 4; ch++) exp1(4, ch, {12'h0, FILL});
        exp_data(0, 5, 21, 1, 0, 0, 20'h0);
        exp_data(1, 5, 22, 1, 0, 0, 20'h0);
        exp_data(2, 5, 31, 1, 0, 0, 20'h0);
        exp_data(3, 5, 1035, 1, 0, 0, 20'h0);
        exp1(10, SIG_STAT, 32'd0);

        tick_to(20);
        cfg_write(0, 37, 1'b1, 0, 20'h0);
        exp_const(0, 22, 59, {12'h0, FILL});
        exp_data(0, 60, 601, 38, 0, 0, 20'h0);

        tick_to(21);
        cfg_write(1, 5, 1'b1, 7, 20'h80000);
        exp_const(1, 23, 28, {12'h0, FILL});
        exp_data(1, 29, 401, 6, 28, 7, 20'h80000);

        tick_to(30);
        cfg_write(2, 0, 1'b1, 10, 20'h00001);
        exp1(32, 2, {12'h0, FILL});
        exp_data(2, 33, 1035, 1, 32, 10, 20'h00001);
        exp1(300, SIG_STAT, 32'd26);

        tick_to(400);
        cfg_write(1, 5, 1'b0, 7, 20'h80000);
        exp_const(1, 402, 501, 32'h0);

        tick_to(410);
        stat_chan_i = 2'd1;
        exp1(420, SIG_STAT, 32'd53);
        exp1(480, SIG_STAT, 32'd53);

        tick_to(500);
        cfg_write(1, 5, 1'b1, 7, 20'h80000);
        exp_const(1, 502, 507, {12'h0, FILL});
        exp_data(1, 508, 1035, 6, 507, 7, 20'h80000);
        exp1(560, SIG_STAT, 32'd60);

        tick_to(600);
        stat_chan_i = 2'd2;
        cfg_write(0, 3, 1'b1, 0, 20'h0);
        exp_const(0, 602, 605, {12'h0, FILL});
        exp_data(0, 606, 1035, 4, 0, 0, 20'h0);
        exp1(1032, SIG_STAT, 32'd99);
        exp1(1033, SIG_STAT, 32'd100);
        exp1(1035, SIG_STAT, 32'd100);

        tick_to(1035);
        rst_i = 1'b1;
        for (int ch = 0; ch < 4; ch++) exp_const(ch, 1036, 1038, 32'h0);
        exp1(1036, SIG_STAT, 32'd0);

        tick_to(1038);
        rst_i = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            exp1(1039, ch, {12'h0, FILL});
            exp_data(ch, 1040, 1050, 1, 0, 0, 20'h0);
        end
        exp1(1045, SIG_STAT, 32'd0);

        tick_to(1055);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
